// File: rtl/kbd_decoder_pkg.sv
// kbd_decoder_pkg: shared encodings for the PS/2 keyboard decoder
package kbd_decoder_pkg;

    // Key event reported on the state output
    typedef enum logic [1:0] {
        EV_IDLE    = 2'b00,
        EV_PRESS   = 2'b01,
        EV_HELD    = 2'b10,
        EV_RELEASE = 2'b11
    } kbd_event_e;

    // Prefix context of the byte decoder
    typedef enum logic [1:0] {
        S_IDLE,
        S_BRK,
        S_EXT,
        S_EXT_BRK
    } dec_state_e;

    localparam logic [7:0] CODE_EXT     = 8'hE0;
    localparam logic [7:0] CODE_BRK     = 8'hF0;
    localparam logic [7:0] CODE_SHIFT_L = 8'h12;
    localparam logic [7:0] CODE_SHIFT_R = 8'h59;

endpackage

// File: rtl/kbd_decoder_scancode_to_ascii.sv
// scancode_to_ascii: set-2 make code to ASCII lookup, letters upper-cased by shift
module scancode_to_ascii
    import kbd_decoder_pkg::*;
(
    input  logic [7:0] code,
    input  logic       shift,
    output logic [7:0] ascii,
    output logic       mapped
);

    logic [7:0] lower;

    // Table yields the unshifted character; 00 marks an unmapped code
    always_comb begin
        lower = 8'h00;
        case (code)
            8'h1C: lower = 8'h61;
            8'h32: lower = 8'h62;
            8'h21: lower = 8'h63;
            8'h23: lower = 8'h64;
            8'h24: lower = 8'h65;
            8'h2B: lower = 8'h66;
            8'h34: lower = 8'h67;
            8'h33: lower = 8'h68;
            8'h43: lower = 8'h69;
            8'h3B: lower = 8'h6A;
            8'h42: lower = 8'h6B;
            8'h4B: lower = 8'h6C;
            8'h3A: lower = 8'h6D;
            8'h31: lower = 8'h6E;
            8'h44: lower = 8'h6F;
            8'h4D: lower = 8'h70;
            8'h15: lower = 8'h71;
            8'h2D: lower = 8'h72;
            8'h1B: lower = 8'h73;
            8'h2C: lower = 8'h74;
            8'h3C: lower = 8'h75;
            8'h2A: lower = 8'h76;
            8'h1D: lower = 8'h77;
            8'h22: lower = 8'h78;
            8'h35: lower = 8'h79;
            8'h1A: lower = 8'h7A;
            8'h45: lower = 8'h30;
            8'h16: lower = 8'h31;
            8'h1E: lower = 8'h32;
            8'h26: lower = 8'h33;
            8'h25: lower = 8'h34;
            8'h2E: lower = 8'h35;
            8'h36: lower = 8'h36;
            8'h3D: lower = 8'h37;
            8'h3E: lower = 8'h38;
            8'h46: lower = 8'h39;
            8'h29: lower = 8'h20;
            8'h5A: lower = 8'h0D;
            8'h66: lower = 8'h08;
            default: lower = 8'h00;
        endcase
    end

    // Only lower-case letters sit at 61 and above, so that range alone takes the shift
    assign ascii  = (shift && lower >= 8'h61) ? lower - 8'h20 : lower;
    assign mapped = lower != 8'h00;

endmodule

// File: rtl/kbd_decoder.sv
// kbd_decoder: PS/2 keyboard frame receiver and key-event decoder
module kbd_decoder
    import kbd_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [1:0] state,
    output logic [7:0] kbd_ascii,
    output logic [7:0] scan_code,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]    ps2c_q;
    logic [2:0]    ps2d_q;
    logic          fall;
    logic          bit_i;
    logic [3:0]    cnt_q;
    logic [8:0]    sh_q;
    logic [TW-1:0] to_q;
    logic          byte_vld_q;
    logic [7:0]    byte_q;
    logic          ferr_q;
    logic          frame_ok;
    dec_state_e    fsm_q, fsm_d;
    kbd_event_e    ev_q, ev_d;
    logic [7:0]    ascii_q, ascii_d;
    logic [7:0]    scan_q, scan_d;
    logic          shl_q, shl_d;
    logic          shr_q, shr_d;
    logic [7:0]    map_ascii;
    logic          map_ok;

    assign fall     = ps2c_q[2] & ~ps2c_q[1];
    assign bit_i    = ps2d_q[2];
    assign frame_ok = bit_i & (^sh_q);

    // Three-flop synchronisers; idle-high so reset never fakes a falling edge
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ps2c_q <= '1;
            ps2d_q <= '1;
        end else begin
            ps2c_q <= {ps2c_q[1:0], ps2_clk};
            ps2d_q <= {ps2d_q[1:0], ps2_data};
        end
    end

    // Frame receiver: a high line at bit 0 is not a start bit, so mid-frame junk is skipped
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt_q      <= '0;
            sh_q       <= '0;
            to_q       <= '0;
            byte_vld_q <= 1'b0;
            byte_q     <= '0;
            ferr_q     <= 1'b0;
        end else begin
            byte_vld_q <= 1'b0;
            ferr_q     <= 1'b0;
            if (fall) begin
                to_q <= '0;
                if (cnt_q == 4'd0) begin
                    cnt_q <= bit_i ? 4'd0 : 4'd1;
                end else if (cnt_q == 4'd10) begin
                    cnt_q      <= '0;
                    byte_q     <= sh_q[7:0];
                    byte_vld_q <= frame_ok;
                    ferr_q     <= ~frame_ok;
                end else begin
                    cnt_q <= cnt_q + 4'd1;
                    sh_q  <= {bit_i, sh_q[8:1]};
                end
            end else if (cnt_q != 4'd0) begin
                if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    cnt_q <= '0;
                    to_q  <= '0;
                end else begin
                    to_q <= to_q + TW'(1);
                end
            end else begin
                to_q <= '0;
            end
        end
    end

    scancode_to_ascii u_map (
        .code   (byte_q),
        .shift  (shl_q | shr_q),
        .ascii  (map_ascii),
        .mapped (map_ok)
    );

    // Decoder next state: pulses decay by default, an accepted byte may override
    always_comb begin
        fsm_d   = fsm_q;
        shl_d   = shl_q;
        shr_d   = shr_q;
        ascii_d = ascii_q;
        scan_d  = scan_q;
        ev_d    = (ev_q == EV_PRESS) ? EV_HELD : (ev_q == EV_RELEASE) ? EV_IDLE : ev_q;
        if (byte_vld_q) begin
            case (fsm_q)
                S_IDLE: begin
                    if (byte_q == CODE_BRK) begin
                        fsm_d = S_BRK;
                    end else if (byte_q == CODE_EXT) begin
                        fsm_d = S_EXT;
                    end else if (byte_q == CODE_SHIFT_L) begin
                        shl_d = 1'b1;
                    end else if (byte_q == CODE_SHIFT_R) begin
                        shr_d = 1'b1;
                    end else if (map_ok && !(ev_q == EV_HELD && byte_q == scan_q)) begin
                        ev_d    = EV_PRESS;
                        ascii_d = map_ascii;
                        scan_d  = byte_q;
                    end
                end
                S_BRK: begin
                    fsm_d = S_IDLE;
                    if (byte_q == CODE_SHIFT_L) begin
                        shl_d = 1'b0;
                    end else if (byte_q == CODE_SHIFT_R) begin
                        shr_d = 1'b0;
                    end else if (ev_q == EV_HELD && byte_q == scan_q) begin
                        ev_d = EV_RELEASE;
                    end
                end
                S_EXT:   fsm_d = (byte_q == CODE_BRK) ? S_EXT_BRK : S_IDLE;
                default: fsm_d = S_IDLE;
            endcase
        end
    end

    // Decoder state register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            fsm_q   <= S_IDLE;
            ev_q    <= EV_IDLE;
            ascii_q <= '0;
            scan_q  <= '0;
            shl_q   <= 1'b0;
            shr_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            ev_q    <= ev_d;
            ascii_q <= ascii_d;
            scan_q  <= scan_d;
            shl_q   <= shl_d;
            shr_q   <= shr_d;
        end
    end

    assign state     = ev_q;
    assign kbd_ascii = ascii_q;
    assign scan_code = scan_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_kbd_decoder.sv
// tb_kbd_decoder: randomized PS/2 traffic checked cycle by cycle against a key-event model
module tb_kbd_decoder;

    localparam int H = 4;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [1:0] state;
    logic [7:0] kbd_ascii;
    logic [7:0] scan_code;
    logic       frame_err;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    kbd_decoder dut (
        .clk       (clk),
        .clrn      (clrn),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .state     (state),
        .kbd_ascii (kbd_ascii),
        .scan_code (scan_code),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                      8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                      8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] misc_codes [3]   = '{8'h29, 8'h5A, 8'h66};
    logic [7:0] misc_ascii [3]   = '{8'h20, 8'h0D, 8'h08};
    logic [7:0] junk_codes [5]   = '{8'h76, 8'h05, 8'h0D, 8'h14, 8'h11};

    // Reference model: key event, held key, shift flags, pending prefix
    logic [1:0] m_st = 2'd0;
    logic [7:0] m_ascii = 8'h00;
    logic [7:0] m_scan = 8'h00;
    bit         m_shl = 0;
    bit         m_shr = 0;
    bit         m_brk = 0;
    bit         m_ext = 0;
    bit         m_ferr = 0;

    typedef struct {int n; logic [7:0] b; bit ok;} frame_t;
    frame_t pend[$];

    typedef struct {logic [1:0] st; logic [7:0] asc; int t;} ev_t;
    ev_t        evlog[$];
    logic [1:0] prev_st = 2'd0;
    int         ferr_cnt = 0;

    task automatic check(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at cycle %0d", nm, got, exp, cyc);
        end
    endtask

    function automatic bit lookup(input logic [7:0] c, input bit sh, output logic [7:0] a);
        a = 8'h00;
        for (int i = 0; i < 26; i++)
            if (letter_codes[i] == c) begin
                a = (sh ? 8'h41 : 8'h61) + 8'(i);
                return 1;
            end
        for (int i = 0; i < 10; i++)
            if (digit_codes[i] == c) begin
                a = 8'h30 + 8'(i);
                return 1;
            end
        for (int i = 0; i < 3; i++)
            if (misc_codes[i] == c) begin
                a = misc_ascii[i];
                return 1;
            end
        return 0;
    endfunction

    function automatic void apply(input logic [7:0] b);
        logic [7:0] a;
        if (m_ext) begin
            m_ext = 0;
            if (!m_brk && b == 8'hF0) m_brk = 1;
            else m_brk = 0;
            if (m_brk) m_ext = 1;
            if (m_brk && m_ext && b != 8'hF0) begin m_brk = 0; m_ext = 0; end
        end else if (m_brk) begin
            m_brk = 0;
            if (b == 8'h12) m_shl = 0;
            else if (b == 8'h59) m_shr = 0;
            else if (m_st == 2'd2 && b == m_scan) m_st = 2'd3;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'h12) begin
            m_shl = 1;
        end else if (b == 8'h59) begin
            m_shr = 1;
        end else if (lookup(b, m_shl || m_shr, a) && !(m_st == 2'd2 && b == m_scan)) begin
            m_st = 2'd1;
            m_ascii = a;
            m_scan = b;
        end
    endfunction

    // Model step and compare on every sampling edge
    always @(negedge clk) begin
        if (!clrn) begin
            m_st = 2'd0; m_ascii = 8'h00; m_scan = 8'h00;
            m_shl = 0; m_shr = 0; m_brk = 0; m_ext = 0; m_ferr = 0;
            pend.delete();
        end else begin
            m_ferr = 0;
            if (m_st == 2'd1) m_st = 2'd2;
            else if (m_st == 2'd3) m_st = 2'd0;
            if (pend.size() > 0 && pend[0].n + 3 == cyc) m_ferr = !pend[0].ok;
            if (pend.size() > 0 && pend[0].n + 4 == cyc) begin
                if (pend[0].ok) apply(pend[0].b);
                void'(pend.pop_front());
            end
        end
        check("state", int'(state), int'(m_st));
        check("kbd_ascii", int'(kbd_ascii), int'(m_ascii));
        check("scan_code", int'(scan_code), int'(m_scan));
        check("frame_err", int'(frame_err), int'(m_ferr));
        if (state != prev_st) evlog.push_back('{state, kbd_ascii, cyc});
        prev_st = state;
        if (frame_err) ferr_cnt++;
    end

    task automatic send_raw(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = fr[i];
            repeat (H) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) pend.push_back('{cyc, b, !(bad_par || bad_stop)});
            repeat (H) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_raw(b, 0, 0, 11);
    endtask

    task automatic settle();
        repeat (8) @(negedge clk);
    endtask

    int         r;
    int         k2;
    logic [7:0] c;
    logic [7:0] b;

    initial begin
        repeat (3) @(negedge clk);
        #2 clrn = 1'b1;
        @(negedge clk);
        #1;
        check("reset_state", int'(state), 0);
        check("reset_ascii", int'(kbd_ascii), 0);
        check("reset_scan", int'(scan_code), 0);
        check("reset_ferr", int'(frame_err), 0);

        // press/hold/release of 'a'
        evlog.delete();
        send(8'h1C); send(8'hF0); send(8'h1C); settle();
        check("r031_events", evlog.size(), 4);
        if (evlog.size() >= 4) begin
            check("r031_press", int'(evlog[0].st), 1);
            check("r031_ascii", int'(evlog[0].asc), 8'h61);
            check("r031_held", int'(evlog[1].st), 2);
            check("r031_press_len", evlog[1].t - evlog[0].t, 1);
            check("r031_release", int'(evlog[2].st), 3);
            check("r031_rel_ascii", int'(evlog[2].asc), 8'h61);
            check("r031_idle", int'(evlog[3].st), 0);
            check("r031_rel_len", evlog[3].t - evlog[2].t, 1);
        end

        // shifted letter
        evlog.delete();
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12); settle();
        check("r032_events", evlog.size(), 4);
        if (evlog.size() >= 1) begin
            check("r032_press", int'(evlog[0].st), 1);
            check("r032_ascii", int'(evlog[0].asc), 8'h41);
        end

        // parity error
        evlog.delete();
        ferr_cnt = 0;
        send_raw(8'h1C, 1, 0, 11); settle();
        check("r033_ferr_cnt", ferr_cnt, 1);
        check("r033_events", evlog.size(), 0);
        check("r033_state", int'(state), 0);

        // extended codes are silent
        evlog.delete();
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); settle();
        check("r035_silent", evlog.size(), 0);
        send(8'h1C); settle();
        check("r035_events", evlog.size(), 2);
        if (evlog.size() >= 1) begin
            check("r035_press", int'(evlog[0].st), 1);
            check("r035_ascii", int'(evlog[0].asc), 8'h61);
        end
        send(8'hF0); send(8'h1C); settle();

        // partial frame abandoned by timeout
        evlog.delete();
        send_raw(8'h2B, 0, 0, 4);
        repeat (60000) @(negedge clk);
        send(8'h2B); settle();
        check("r034_events", evlog.size(), 2);
        if (evlog.size() >= 1) check("r034_press", int'(evlog[0].st), 1);
        check("r034_scan", int'(scan_code), 8'h2B);
        check("r034_ascii", int'(kbd_ascii), 8'h66);

        // reset in the middle of a frame while a key is held
        check("r036_pre_state", int'(state), 2);
        send_raw(8'h1C, 0, 0, 5);
        @(negedge clk);
        #2 clrn = 1'b0;
        #1;
        check("r036_state", int'(state), 0);
        check("r036_ascii", int'(kbd_ascii), 0);
        check("r036_scan", int'(scan_code), 0);
        check("r036_ferr", int'(frame_err), 0);
        @(negedge clk);
        #2 clrn = 1'b1;
        settle();
        evlog.delete();
        send(8'h1C); settle();
        check("r036_events", evlog.size(), 2);
        if (evlog.size() >= 1) begin
            check("r036_press", int'(evlog[0].st), 1);
            check("r036_press_ascii", int'(evlog[0].asc), 8'h61);
        end

        // randomized traffic, checked by the model every cycle
        for (int k = 0; k < 90; k++) begin
            r  = $urandom_range(0, 99);
            k2 = $urandom_range(0, 38);
            c  = (k2 < 26) ? letter_codes[k2] : (k2 < 36) ? digit_codes[k2 - 26] : misc_codes[k2 - 36];
            if (r < 35) begin
                send(c);
            end else if (r < 55) begin
                send(8'hF0);
                send($urandom_range(0, 1) ? m_scan : c);
            end else if (r < 65) begin
                b = $urandom_range(0, 1) ? 8'h12 : 8'h59;
                if ($urandom_range(0, 1)) send(8'hF0);
                send(b);
            end else if (r < 73) begin
                send(8'hE0);
                if ($urandom_range(0, 1)) send(8'hF0);
                send($urandom_range(0, 1) ? 8'h75 : c);
            end else if (r < 80) begin
                send(junk_codes[$urandom_range(0, 4)]);
            end else if (r < 90) begin
                send(m_scan);
            end else begin
                k2 = $urandom_range(0, 1);
                send_raw(8'($urandom_range(0, 255)), k2 == 0, k2 == 1, 11);
            end
            repeat ($urandom_range(0, 15)) @(negedge clk);
        end

        repeat (20) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/kbd_decoder.md
KBD_DECODER -- requirements
Module: kbd_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning clk cycles without a PS/2 falling edge before a partial frame is abandoned (1 ms at 50 MHz).
REQ-002 SHALL have port clk  input  1  system clock (50 MHz); all logic is single-clock.
REQ-003 SHALL have port clrn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous to clk.
REQ-005 SHALL have port ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous to clk.
REQ-006 SHALL have port state  output  2  key event: 00 idle, 01 press pulse, 10 held, 11 release pulse.
REQ-007 SHALL have port kbd_ascii  output  8  ASCII of the current or last key; valid whenever state != 00.
REQ-008 SHALL have port scan_code  output  8  last accepted make code.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on a parity, start or stop error.

Function
REQ-010 SHALL synchronise ps2_clk and ps2_data through 3 flops; a falling edge is detected when the two oldest synchronised ps2_clk samples are 1 then 0.
REQ-011 SHALL sample ps2_data on each detected falling edge into an 11-bit frame: start 0, 8 data bits LSB first, odd parity, stop 1.
REQ-012 SHALL accept a byte only when start = 0, stop = 1 and the XOR of the data and parity bits = 1; otherwise it SHALL discard the frame and pulse frame_err.
REQ-013 SHALL clear the bit counter when TIMEOUT_CYCLES pass with no falling edge while the count is 1..10; no byte and no frame_err are produced.
REQ-014 SHALL deliver each accepted byte to the decoder FSM exactly 1 cycle after the stop-bit edge.
REQ-015 The decoder FSM SHALL have states IDLE, BRK (F0 seen), EXT (E0 seen) and EXT_BRK (E0 F0 seen).
REQ-016 In IDLE: byte F0 -> BRK; byte E0 -> EXT; make code 12 or 59 sets shift_l or shift_r respectively with no event.
REQ-017 In IDLE, a mapped make code SHALL drive state = 01 for exactly 1 cycle, then 10, and latch kbd_ascii and scan_code.
REQ-018 A make code equal to the held code while state = 10 (typematic repeat) SHALL produce no new 01 pulse.
REQ-019 An unmapped make code in IDLE SHALL be ignored, leaving all outputs unchanged.
REQ-020 In BRK, the next byte returns the FSM to IDLE: 12 or 59 clears the matching shift flag.
REQ-021 In BRK, a byte equal to the held code SHALL drive state = 11 for 1 cycle then 00, with kbd_ascii held during the 11 cycle.
REQ-022 In BRK, any other byte SHALL be ignored.
REQ-023 EXT and EXT_BRK SHALL consume extended codes with no event: EXT goes to EXT_BRK on F0 and to IDLE otherwise; EXT_BRK goes to IDLE on any byte.
REQ-024 A new mapped make code while another key is held SHALL replace it, giving 01 for 1 cycle then 10.
REQ-025 ASCII mapping: letters 1C..1A (a-z) give 61..7A, or 41..5A if shift_l|shift_r; digits 45,16,1E,26,25,2E,36,3D,3E,46 give 30..39; 29 gives 20; 5A gives 0D; 66 gives 08.
REQ-026 A press event and a release pulse SHALL never occur in the same cycle; state holds a single value per cycle.

Reset
REQ-027 On clrn = 0, asynchronously: state = 00, kbd_ascii = 00, scan_code = 00, frame_err = 0, FSM = IDLE, shift flags = 0, bit counter = 0, timeout counter = 0, synchroniser flops = 1.
REQ-028 After clrn deasserts, a frame in progress SHALL be ignored until a timeout or a clean start bit; the first full frame after release SHALL be accepted.

Structure
REQ-029 A shared package SHALL hold the state encodings (00/01/10/11), the prefix codes E0 and F0, and the shift codes 12 and 59.
REQ-030 The scan-code to ASCII table SHALL be a separate combinational sub-module, scancode_to_ascii (inputs: code, shift; outputs: ascii, mapped).

Verification
REQ-031 Frames 1C, F0, 1C -> state 01 for 1 cycle with kbd_ascii = 61, then 10, then 11 for 1 cycle, then 00.
REQ-032 Frames 12, 1C, F0 1C, F0 12 -> kbd_ascii = 41 and no event for the 12 frames.
REQ-033 Frame 1C sent with even parity -> frame_err pulses once and state stays 00.
REQ-034 Four bits of a frame, then 60000 idle cycles, then a full 2B frame -> the partial frame is dropped and the 2B frame is accepted as a key press (state 01, scan_code = 2B).
REQ-035 Frames E0, 75, E0, F0, 75 -> no event; the following 1C frame gives 01 with ascii 61.
REQ-036 clrn pulsed low after bit 5 of a 1C frame -> all outputs are 00 immediately; a subsequent clean 1C frame gives 01/61.
